// File: rtl/accel_tilt_leds.sv
// Tilt-to-LED spirit level: boxcar-averages accel_x/accel_y captured every SAMPLE_PERIOD clocks and maps
// the filtered X onto 8 LEDs with hysteresis. Define ACCEL_TILT_BAR_EN for a bar display instead of one-hot.
module accel_tilt_leds #(
   parameter int SAMPLE_PERIOD = 250_000,
   parameter int AVG_LOG2      = 3,
   parameter int SCALE_SHIFT   = 6,
   parameter int HYST_COUNT    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] accel_x,
   input  logic signed [15:0] accel_y,
   output logic signed [15:0] filt_x,
   output logic signed [15:0] filt_y,
   output logic               filt_valid,
   output logic [2:0]         led_idx,
   output logic [7:0]         led
);

   localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int AW = 16 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam int SW = $clog2(HYST_COUNT + 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [CW-1:0] NSAMP_LAST  = CW'((1 << AVG_LOG2) - 1);
   localparam logic [SW-1:0] HYST_LIM    = SW'(HYST_COUNT);

   typedef enum logic [1:0] {
      ST_SAMPLE = 2'd0,
      ST_AVG    = 2'd1,
      ST_MAP    = 2'd2
   } state_t;

   state_t               r_state;
   logic [PW-1:0]        r_period;
   logic [CW-1:0]        r_nsamp;
   logic signed [AW-1:0] r_acc_x;
   logic signed [AW-1:0] r_acc_y;
   logic signed [15:0]   r_filt_x;
   logic signed [15:0]   r_filt_y;
   logic                 r_filt_valid;
   logic [2:0]           r_led_idx;
   logic [7:0]           r_led;
   logic [2:0]           r_pend;
   logic [SW-1:0]        r_streak;

   logic                 w_tick;
   logic                 w_capture;
   logic                 w_last;
   logic signed [AW-1:0] w_ext_x;
   logic signed [AW-1:0] w_ext_y;
   logic signed [15:0]   w_q;
   logic [2:0]           w_cand;
   logic [2:0]           w_pend_n;
   logic [SW-1:0]        w_streak_n;
   logic                 w_move;

   // LED image for a bin index; both builds show 8'b0001_0000 for the centre bin 4.
   function automatic logic [7:0] f_led_pattern(input logic [2:0] idx);
      logic [7:0] v;
      v = 8'd0;
`ifdef ACCEL_TILT_BAR_EN
      for (int i = 0; i < 8; i++) begin
         if (idx >= 3'd4) begin
            v[i] = (i >= 4) && (i <= int'(idx));
         end else begin
            v[i] = (i >= int'(idx)) && (i <= 3);
         end
      end
`else
      v = 8'd1 << idx;
`endif
      return v;
   endfunction

   assign w_tick    = (r_period == PERIOD_LAST);
   assign w_capture = w_tick && (r_state != ST_AVG);
   assign w_last    = (r_nsamp == NSAMP_LAST);
   assign w_ext_x   = AW'(accel_x);
   assign w_ext_y   = AW'(accel_y);

   // Free-running capture timebase, independent of the FSM state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_period <= PW'(0);
      end else if (w_tick) begin
         r_period <= PW'(0);
      end else begin
         r_period <= r_period + PW'(1);
      end
   end

   // Accumulators: a capture landing in ST_MAP starts the next set, so the cadence holds for short periods.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_x <= AW'(0);
         r_acc_y <= AW'(0);
         r_nsamp <= CW'(0);
      end else if (r_state == ST_AVG) begin
         r_acc_x <= AW'(0);
         r_acc_y <= AW'(0);
         r_nsamp <= CW'(0);
      end else if (w_capture) begin
         r_acc_x <= r_acc_x + w_ext_x;
         r_acc_y <= r_acc_y + w_ext_y;
         r_nsamp <= r_nsamp + CW'(1);
      end
   end

   // Candidate bin: floor-shift of filtered X clamped to -4..+3, offset to 0..7.
   always_comb begin
      w_q = r_filt_x >>> SCALE_SHIFT;
      if (w_q > 16'sd3) begin
         w_cand = 3'd7;
      end else if (w_q < -16'sd4) begin
         w_cand = 3'd0;
      end else begin
         w_cand = 3'(w_q + 16'sd4);
      end
   end

   // Hysteresis bookkeeping for the candidate against the displayed bin.
   always_comb begin
      w_pend_n   = r_pend;
      w_streak_n = SW'(0);
      if (w_cand == r_led_idx) begin
         w_pend_n   = r_pend;
         w_streak_n = SW'(0);
      end else if (w_cand == r_pend) begin
         w_pend_n   = r_pend;
         w_streak_n = r_streak + SW'(1);
      end else begin
         w_pend_n   = w_cand;
         w_streak_n = SW'(1);
      end
   end

   assign w_move = (w_cand != r_led_idx) && (w_streak_n >= HYST_LIM);

   // Control FSM with registered filter and LED outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_SAMPLE;
         r_filt_x     <= 16'sd0;
         r_filt_y     <= 16'sd0;
         r_filt_valid <= 1'b0;
         r_led_idx    <= 3'd4;
         r_led        <= 8'b0001_0000;
         r_pend       <= 3'd0;
         r_streak     <= SW'(0);
      end else begin
         r_filt_valid <= 1'b0;
         case (r_state)
            ST_SAMPLE: begin
               if (w_capture && w_last) begin
                  r_state <= ST_AVG;
               end
            end
            ST_AVG: begin
               r_filt_x     <= 16'(r_acc_x >>> AVG_LOG2);
               r_filt_y     <= 16'(r_acc_y >>> AVG_LOG2);
               r_filt_valid <= 1'b1;
               r_state      <= ST_MAP;
            end
            ST_MAP: begin
               r_pend <= w_pend_n;
               if (w_move) begin
                  r_led_idx <= w_cand;
                  r_led     <= f_led_pattern(w_cand);
                  r_streak  <= SW'(0);
               end else begin
                  r_streak  <= w_streak_n;
               end
               r_state <= (w_capture && w_last) ? ST_AVG : ST_SAMPLE;
            end
            default: begin
               r_state <= ST_SAMPLE;
            end
         endcase
      end
   end

   assign filt_x     = r_filt_x;
   assign filt_y     = r_filt_y;
   assign filt_valid = r_filt_valid;
   assign led_idx    = r_led_idx;
   assign led        = r_led;

endmodule

// File: tb/tb_accel_tilt_leds.sv
// Randomized bench for accel_tilt_leds against a cycle-indexed model built from captured sample lists.
module tb_accel_tilt_leds;

   localparam int SP = 4;
   localparam int AL = 2;
   localparam int SS = 6;
   localparam int HC = 2;
   localparam int N  = 1 << AL;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [15:0] accel_x = 16'sd0;
   logic signed [15:0] accel_y = 16'sd0;
   logic signed [15:0] filt_x;
   logic signed [15:0] filt_y;
   logic               filt_valid;
   logic [2:0]         led_idx;
   logic [7:0]         led;

   always #5 clk = ~clk;

   accel_tilt_leds #(
      .SAMPLE_PERIOD(SP),
      .AVG_LOG2     (AL),
      .SCALE_SHIFT  (SS),
      .HYST_COUNT   (HC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .accel_x   (accel_x),
      .accel_y   (accel_y),
      .filt_x    (filt_x),
      .filt_y    (filt_y),
      .filt_valid(filt_valid),
      .led_idx   (led_idx),
      .led       (led)
   );

   int n_checks = 0;
   int n_errors = 0;

   // model state: c = cycles since reset release
   int c = 0;
   int qx[$];
   int qy[$];
   int pend_fx = 0, pend_fy = 0;
   int avg_due = -1, led_due = -1;
   int e_fx = 0, e_fy = 0, e_idx = 4;
   int m_pend = 0, m_run = 0, n_avgs = 0;
   int cval_x = 0, cval_y = 0, rbase = 0;
   int tblx[4] = '{100, 100, 100, -1};
   int tbly[4] = '{-1, -1, -1, -2};

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, c, got, exp);
      end
   endtask

   function automatic int fdiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int led_of(input int idx);
      int v;
      v = 0;
`ifdef ACCEL_TILT_BAR_EN
      if (idx >= 4) begin
         for (int i = 4; i <= idx; i++) v = v | (1 << i);
      end else begin
         for (int i = idx; i <= 3; i++) v = v | (1 << i);
      end
`else
      v = 1 << idx;
`endif
      return v;
   endfunction

   task automatic step(input logic r, input int x, input int y);
      int nc;
      int sx, sy, cand;
      rst     = r;
      accel_x = 16'(x);
      accel_y = 16'(y);
      if (r) begin
         nc = 0;
         qx.delete(); qy.delete();
         avg_due = -1; led_due = -1;
         e_fx = 0; e_fy = 0; e_idx = 4;
         m_pend = 0; m_run = 0; n_avgs = 0;
      end else begin
         nc = c + 1;
         if ((c % SP) == (SP - 1)) begin
            qx.push_back(int'(accel_x));
            qy.push_back(int'(accel_y));
            if (qx.size() == N) begin
               sx = 0; sy = 0;
               foreach (qx[i]) sx += qx[i];
               foreach (qy[i]) sy += qy[i];
               pend_fx = fdiv(sx, N);
               pend_fy = fdiv(sy, N);
               avg_due = c + 2;
               led_due = c + 3;
               n_avgs++;
               qx.delete(); qy.delete();
            end
         end
      end
      @(posedge clk);
      #1;
      c = nc;
      if (c == avg_due) begin
         e_fx = pend_fx;
         e_fy = pend_fy;
      end
      if (c == led_due) begin
         cand = fdiv(e_fx, 1 << SS);
         if (cand > 3) cand = 3;
         if (cand < -4) cand = -4;
         cand = cand + 4;
         if (cand == e_idx) begin
            m_run = 0;
         end else begin
            if (cand == m_pend) m_run++;
            else begin
               m_pend = cand;
               m_run  = 1;
            end
            if (m_run >= HC) begin
               e_idx = cand;
               m_run = 0;
            end
         end
      end
      check_val("filt_valid", int'(filt_valid), (c == avg_due) ? 1 : 0);
      check_val("filt_x", int'(filt_x), e_fx);
      check_val("filt_y", int'(filt_y), e_fy);
      check_val("led_idx", int'(led_idx), e_idx);
      check_val("led", int'(led), led_of(e_idx));
   endtask

   // modes: 0 constant, 1 table at captures, 2 alternating bins 7/6, 3 random bins, 4 full random
   task automatic run(input int mode, input int ncyc);
      bit capt;
      int x, y;
      for (int k = 0; k < ncyc; k++) begin
         capt = ((c % SP) == (SP - 1));
         x = int'($urandom);
         y = int'($urandom);
         case (mode)
            0: begin x = cval_x; y = cval_y; end
            1: if (capt) begin x = tblx[qx.size() % 4]; y = tbly[qy.size() % 4]; end
            2: if (capt) x = ((n_avgs % 2) == 0) ? 200 : 150;
            3: begin
               if ((k % 32) == 0) rbase = int'($urandom_range(1400, 0)) - 700;
               if (capt) x = rbase + int'($urandom_range(40, 0)) - 20;
            end
            default: ;
         endcase
         step(1'b0, x, y);
      end
   endtask

   initial begin
      repeat (5) step(1'b1, 0, 0);
      cval_x = 200; cval_y = 37;
      run(0, 40);
      step(1'b1, 0, 0);
      run(1, 20);
      cval_x = -32768; cval_y = 32767;
      run(0, 48);
      cval_x = -100; cval_y = -5;
      run(0, 48);
      step(1'b1, 0, 0);
      run(2, 96);
      step(1'b1, 0, 0);
      cval_x = 500; cval_y = 11;
      run(0, 8);
      step(1'b1, 0, 0);
      cval_x = 300; cval_y = -7;
      run(0, 40);
      run(3, 640);
      run(4, 200);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
